// File: rtl/seq_parser_pkg.sv
// Shared types, default widths and helpers for the sequence parser with output FIFO.
package seq_parser_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REC_BITS_DEF   = 296;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  // Parser states: gathering beats of a packet, or dropping the tail of an overlong one.
  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  // Integer ceiling division, used to derive the beats-per-record count.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/seq_parser_fifo_rec_fifo.sv
// rec_fifo: synchronous record FIFO. A push against a full FIFO is refused (drop=1)
// unless a pop happens in the same cycle, in which case both take effect.
// head shows the oldest entry while non-empty and all-zero when empty.
module rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [0:WIDTH-1] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [0:WIDTH-1] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             rd_en;
  logic             wr_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == (AW+1)'(0));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;
  assign head  = empty ? {WIDTH{1'b0}} : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents are only visible through head while occupied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/seq_parser_fifo.sv
// seq_parser_fifo: packs DATA_W-bit beats framed by dataIN_last into REC_BITS-bit
// records and queues them in a FIFO_DEPTH-entry output FIFO. Short, overlong and
// FIFO-overflow packets pulse packetLost and bump a saturating lost_count.
// Optional build macro SEQ_PARSER_BACKPRESSURE_EN: stall input while the FIFO is
// full and not being popped, so overflow drops cannot happen.
module seq_parser_fifo
  import seq_parser_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REC_BITS   = REC_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic                dataIn_val,
  output logic                dataIn_ready,
  input  logic                dataIN_last,
  output logic [0:REC_BITS-1] dataOut,
  output logic                dataOut_val,
  input  logic                dataOut_ready,
  output logic                packetLost,
  output logic [CNT_W-1:0]    lost_count
);

  localparam int WORDS     = ceil_div(REC_BITS, DATA_W);
  localparam int PBUF_W    = (WORDS - 1) * DATA_W;
  localparam int LAST_BITS = REC_BITS - PBUF_W;
  localparam int WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WORDS - 1);

  state_t            state;
  state_t            state_next;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_next;
  // Holds every beat except the final one; the final beat goes straight to the FIFO.
  logic [0:PBUF_W-1] pbuf;
  logic [0:PBUF_W-1] pbuf_next;
  logic [0:REC_BITS-1] rec_in;
  logic              run;
  logic              accept;
  logic              push;
  logic              fmt_lost;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              lost_ev;

`ifdef SEQ_PARSER_BACKPRESSURE_EN
  assign dataIn_ready = run & (~fifo_full | dataOut_ready);
`else
  assign dataIn_ready = run;
`endif

  assign accept      = dataIn_val & dataIn_ready;
  assign rec_in      = {pbuf, dataIn[DATA_W-1 -: LAST_BITS]};
  assign dataOut_val = ~fifo_empty;
  assign lost_ev     = fmt_lost | fifo_drop;

  // Parser state, beat counter, packing buffer and loss reporting registers.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state      <= S_COLLECT;
      wcnt       <= '0;
      pbuf       <= '0;
      run        <= 1'b0;
      packetLost <= 1'b0;
      lost_count <= '0;
    end else begin
      state      <= state_next;
      wcnt       <= wcnt_next;
      pbuf       <= pbuf_next;
      run        <= 1'b1;
      packetLost <= lost_ev;
      if (lost_ev && (lost_count != {CNT_W{1'b1}})) begin
        lost_count <= lost_count + CNT_W'(1);
      end
    end
  end

  // Next-state, packing and push/loss decisions for each accepted beat.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    pbuf_next  = pbuf;
    push       = 1'b0;
    fmt_lost   = 1'b0;
    if (accept) begin
      case (state)
        S_COLLECT: begin
          if (wcnt != WCNT_MAX) begin
            pbuf_next[int'(wcnt)*DATA_W +: DATA_W] = dataIn;
          end else begin
            pbuf_next = pbuf;
          end
          if (dataIN_last) begin
            wcnt_next = '0;
            if (wcnt == WCNT_MAX) begin
              push = 1'b1;
            end else begin
              fmt_lost = 1'b1;
            end
          end else if (wcnt == WCNT_MAX) begin
            state_next = S_DISCARD;
            wcnt_next  = '0;
          end else begin
            wcnt_next = wcnt + WCNT_W'(1);
          end
        end
        S_DISCARD: begin
          if (dataIN_last) begin
            fmt_lost   = 1'b1;
            state_next = S_COLLECT;
            wcnt_next  = '0;
          end else begin
            state_next = S_DISCARD;
          end
        end
        default: begin
          state_next = S_COLLECT;
          wcnt_next  = '0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  rec_fifo #(
    .WIDTH (REC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset_b),
    .push  (push),
    .din   (rec_in),
    .pop   (dataOut_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .head  (dataOut)
  );

endmodule

// File: tb/tb_seq_parser_fifo.sv
// Scoreboard bench for seq_parser_fifo: stimulus pushes expected records and expected
// lost_count values into queues; a negedge monitor pops and compares them.
module tb_seq_parser_fifo;

  localparam int DATA_W = 32;
  localparam int REC_BITS = 296;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                reset_b = 1'b1;
  logic [DATA_W-1:0]   dataIn = '0;
  logic                dataIn_val = 1'b0;
  logic                dataIn_ready;
  logic                dataIN_last = 1'b0;
  logic [0:REC_BITS-1] dataOut;
  logic                dataOut_val;
  logic                dataOut_ready = 1'b1;
  logic                packetLost;
  logic [CNT_W-1:0]    lost_count;

  logic [0:REC_BITS-1] exp_q[$];
  int                  lost_q[$];
  int                  passed = 0;
  int                  total = 0;
  int                  exp_cnt = 0;
  logic [31:0]         pkt [0:9];

  seq_parser_fifo dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .dataIn        (dataIn),
    .dataIn_val    (dataIn_val),
    .dataIn_ready  (dataIn_ready),
    .dataIN_last   (dataIN_last),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .packetLost    (packetLost),
    .lost_count    (lost_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [295:0] act, input logic [295:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [0:REC_BITS-1] mk_rec();
    logic [31:0] w9;
    w9 = pkt[9];
    return {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5], pkt[6], pkt[7], pkt[8], w9[31:24]};
  endfunction

  task automatic note_lost();
    exp_cnt++;
    lost_q.push_back(exp_cnt);
  endtask

  // Drive one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] w, input logic last);
    int n;
    dataIn = w;
    dataIN_last = last;
    dataIn_val = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dataIn_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!dataIn_ready) begin
      total++;
      $display("FAIL beat_stall: dataIn_ready got 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    dataIn_val = 1'b0;
    dataIN_last = 1'b0;
  endtask

  task automatic send_good(input logic [31:0] w0, input logic [31:0] w9, input bit stored);
    pkt[0] = w0;
    for (int k = 1; k < 9; k++) pkt[k] = 32'(k + 1);
    pkt[9] = w9;
    for (int k = 0; k < 10; k++) send_beat(pkt[k], (k == 9));
    if (stored) exp_q.push_back(mk_rec());
    else note_lost();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && lost_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 296'(exp_q.size() + lost_q.size()), 296'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare popped records and every packetLost pulse against the scoreboard.
  always @(negedge clk) begin
    if (dataOut_val && dataOut_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_unexpected: got record %h expected none", dataOut);
      end else begin
        chk("record", dataOut, exp_q.pop_front());
      end
    end
    if (packetLost) begin
      if (lost_q.size() == 0) begin
        total++;
        $display("FAIL lost_unexpected: got packetLost 1 expected 0 (lost_count %0d)", lost_count);
      end else begin
        chk("lost_count_at_pulse", 296'(lost_count), 296'(lost_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataIn_ready", 296'(dataIn_ready), 296'd0);
    chk("rst_dataOut_val", 296'(dataOut_val), 296'd0);
    chk("rst_dataOut", dataOut, 296'd0);
    chk("rst_packetLost", 296'(packetLost), 296'd0);
    chk("rst_lost_count", 296'(lost_count), 296'd0);
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 296'(dataIn_ready), 296'd1);

    // Good packet: 1..9 then 0xAB123456, record visible the next cycle
    send_good(32'h0000_0001, 32'hAB12_3456, 1'b1);
    @(negedge clk);
    chk("good_val_latency", 296'(dataOut_val), 296'd1);
    chk("good_word0", 296'(dataOut[0:31]), 296'h0000_0001);
    chk("good_tail_byte", 296'(dataOut[288:295]), 296'hAB);
    chk("good_no_lost", 296'(packetLost), 296'd0);
    @(posedge clk);
    #1;
    drain();

    // Short packet: 3 beats
    send_beat(32'hDEAD_0001, 1'b0);
    send_beat(32'hDEAD_0002, 1'b0);
    send_beat(32'hDEAD_0003, 1'b1);
    note_lost();
    @(negedge clk);
    chk("short_pulse_hi", 296'(packetLost), 296'd1);
    chk("short_count", 296'(lost_count), 296'd1);
    @(negedge clk);
    chk("short_pulse_lo", 296'(packetLost), 296'd0);
    chk("short_no_record", 296'(dataOut_val), 296'd0);
    @(posedge clk);
    #1;
    drain();

    // Overlong packet: 12 beats, then a good packet
    for (int k = 0; k < 12; k++) send_beat(32'h0F00_0000 + 32'(k), (k == 11));
    note_lost();
    send_good(32'hC0FF_EE00, 32'h5A00_0000, 1'b1);
    drain();
    chk("overlong_count", 296'(lost_count), 296'd2);

`ifndef SEQ_PARSER_BACKPRESSURE_EN
    // Full FIFO: 5 tagged packets with no consumer, 5th dropped
    dataOut_ready = 1'b0;
    send_good(32'h0000_0011, 32'h1100_0000, 1'b1);
    send_good(32'h0000_0022, 32'h2200_0000, 1'b1);
    send_good(32'h0000_0033, 32'h3300_0000, 1'b1);
    send_good(32'h0000_0044, 32'h4400_0000, 1'b1);
    send_good(32'h0000_0055, 32'h5500_0000, 1'b0);
    @(negedge clk);
    chk("full_head_tag", 296'(dataOut[0:31]), 296'h11);
    chk("full_count", 296'(lost_count), 296'd3);
    @(posedge clk);
    #1;
    dataOut_ready = 1'b1;
    drain();
    chk("full_emptied", 296'(dataOut_val), 296'd0);
`else
    // Backpressure: full FIFO stalls the input instead of dropping
    dataOut_ready = 1'b0;
    send_good(32'h0000_0011, 32'h1100_0000, 1'b1);
    send_good(32'h0000_0022, 32'h2200_0000, 1'b1);
    send_good(32'h0000_0033, 32'h3300_0000, 1'b1);
    send_good(32'h0000_0044, 32'h4400_0000, 1'b1);
    @(negedge clk);
    chk("bp_ready_low", 296'(dataIn_ready), 296'd0);
    chk("bp_no_loss", 296'(lost_count), 296'(exp_cnt));
    dataOut_ready = 1'b1;
    #1;
    chk("bp_ready_restored", 296'(dataIn_ready), 296'd1);
    drain();
`endif

    // Reset mid-packet: partial record discarded silently
    for (int k = 0; k < 5; k++) send_beat(32'h7700_0000 + 32'(k), 1'b0);
    reset_b = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    chk("midrst_val", 296'(dataOut_val), 296'd0);
    chk("midrst_count", 296'(lost_count), 296'd0);
    chk("midrst_pulse", 296'(packetLost), 296'd0);
    chk("midrst_ready", 296'(dataIn_ready), 296'd0);
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    send_good(32'h0BAD_F00D, 32'hFEDC_BA98, 1'b1);
    drain();
    chk("post_rst_count", 296'(lost_count), 296'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_parser_fifo.md
Name: seq_parser_fifo

Overview:
- Parametrised successor to the sequence parser.
- Collects a stream of DATA_W-bit words, framed by dataIN_last, into fixed REC_BITS-bit records.
- Queues completed records in an output FIFO of FIFO_DEPTH entries with valid/ready handshake.
- Flags every malformed or dropped packet on packetLost and counts losses; sits between the link receiver and downstream record consumers.

Parameters:
- DATA_W, 32, input word width.
- REC_BITS, 296, record width in bits.
- WORDS, ceil(REC_BITS/DATA_W) = 10, beats per valid packet (derived localparam).
- FIFO_DEPTH, 4, output record FIFO entries (power of 2, >= 2).
- CNT_W, 16, width of lost-packet counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_b  in  1  asynchronous, active-high reset; 1 clears all state immediately.
- dataIn  in  DATA_W  input word.
- dataIn_val  in  1  word valid.
- dataIn_ready  out  1  block accepts word.
- dataIN_last  in  1  word is final beat of packet.
- dataOut  out  [0:REC_BITS-1]  head record; index 0 = MSB of first word.
- dataOut_val  out  1  FIFO non-empty.
- dataOut_ready  in  1  consumer pops head.
- packetLost  out  1  one-cycle pulse per lost packet.
- lost_count  out  CNT_W  saturating lost-packet count.

Behaviour:
- Beat accepted when dataIn_val & dataIn_ready.
- Packing: word k fills dataOut[k*DATA_W +: DATA_W] ascending, MSB first. Final word keeps only its top REC_BITS-(WORDS-1)*DATA_W bits; low bits discarded.
- FSM COLLECT (word counter wcnt 0..WORDS-1), accepted beat:
  - last && wcnt==WORDS-1: push record; wcnt=0.
  - last && wcnt<WORDS-1: short packet, lost; wcnt=0.
  - !last && wcnt==WORDS-1: overlong; go to DISCARD.
  - otherwise: wcnt++.
- FSM DISCARD: drop beats until one with last, then lost; go to COLLECT with wcnt=0.
- Push when FIFO full and no pop that cycle: record dropped, lost. Full with simultaneous pop: push succeeds, occupancy unchanged.
- Pop: dataOut_val & dataOut_ready. Empty pop ignored.
- Latency: record on dataOut with dataOut_val=1 the cycle after its final beat is accepted (empty FIFO). Records leave in arrival order.
- dataOut = head entry while non-empty, all-zero when empty.
- packetLost: registered, high exactly one cycle after the offending beat. lost_count increments in the same cycle and saturates at all-ones.
- dataIn_ready = 1 whenever out of reset (no backpressure build).
- Reset values: dataIn_ready 0 during reset, dataOut 0, dataOut_val 0, packetLost 0, lost_count 0, FSM=COLLECT, wcnt 0, FIFO empty.
- Reset mid-packet discards the partial record; no packetLost is raised.

Optional Feature:
- Macro SEQ_PARSER_BACKPRESSURE_EN.
- Defined: dataIn_ready = !full | dataOut_ready; full-FIFO drops cannot occur. Short and overlong packets are still lost.
- Undefined: behaviour exactly as above.

Decomposition:
- Package seq_parser_pkg holds the state enum (S_COLLECT, S_DISCARD), the ceil-div function for WORDS, and the default widths.
- One natural sub-module, rec_fifo: parametrised width/depth sync FIFO with push, pop, full, empty, head. The parser FSM and packer live in the top.

Test Plan:
- Good packet: 10 beats 0x00000001..0x00000009, then 0xAB123456 with last, dataOut_ready=1 -> next cycle dataOut_val=1, dataOut[0:31]=0x00000001, dataOut[288:295]=0xAB, packetLost=0.
- Short packet: 3 beats, last on 3rd -> packetLost pulse 1 cycle, lost_count=1, dataOut_val stays 0.
- Overlong: 12 beats, last on 12th -> no record, packetLost after beat 12, lost_count=1; following good packet emitted correctly.
- Full FIFO: dataOut_ready=0, 5 good packets tagged 0x11..0x55 in word 0 -> 4 stored, 5th lost (lost_count=1); then dataOut_ready=1 -> pops 0x11,0x22,0x33,0x44 in order.
- Reset mid-packet: assert reset_b after 5 beats -> dataOut_val=0, lost_count=0, no packetLost; next 10-beat packet produces correct record.
- SEQ_PARSER_BACKPRESSURE_EN: FIFO full, dataOut_ready=0 -> dataIn_ready=0, lost_count stays 0; raising dataOut_ready restores dataIn_ready the same cycle.
